// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Access size codes as driven on d_size; 2'b11 is illegal.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/mem_lane_ctl.sv
// Byte-lane helper: byte enables, store-lane replication, load alignment
// shift and the alignment fault flag, all from size and addr[1:0].
module mem_lane_ctl
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  // Per-size lane decode; the illegal size code is flagged as a fault.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_o       = 4'b0011 << off_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = off_i[0];
      end
      SZ_W: begin
        be_o       = 4'b1111;
        misalign_o = |off_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

  // Loads come back right-justified; extension is left to the CPU.
  assign rdata_o = rdata_i >> {off_i, 3'b000};

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and load/store for one single-port
// memory. Data wins by default; a starvation counter forces a fetch grant
// after STARVE_MAX back-to-back data grants. Faulting requests are answered
// locally and counted.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES  = 4096,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  seg_faults
);

  state_e      state_q, state_d;
  owner_e      own_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        we_q, err_q;
  logic [7:0]  starve_q, seg_q;

  logic        idle, issue, resp;
  logic        gnt_d, gnt_i, gnt, fault;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_we;
  logic [1:0]  ln_size, ln_off;
  logic [3:0]  ln_be;
  logic [31:0] ln_wdata, ln_rdata;
  logic        ln_misalign;

  assign idle  = (state_q == S_IDLE);
  assign issue = (state_q == S_ISSUE);
  assign resp  = (state_q == S_RESP);

  // Priority arbitration: data first unless fetch has waited STARVE_MAX grants.
  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if (d_req && (!i_req || (starve_q < 8'(STARVE_MAX)))) gnt_d = 1'b1;
    else if (i_req)                                         gnt_i = 1'b1;
  end

  assign gnt = idle && (gnt_d || gnt_i);

  // Granted request fields; fetch is treated as a word read.
  assign req_addr  = gnt_d ? d_addr  : i_addr;
  assign req_size  = gnt_d ? d_size  : SZ_W;
  assign req_we    = gnt_d && d_we;
  assign req_wdata = gnt_d ? d_wdata : 32'h0;

  // One lane decoder: live request in IDLE for the fault check, latched
  // request afterwards for enables, store lanes and the load shift.
  assign ln_size = idle ? req_size       : size_q;
  assign ln_off  = idle ? req_addr[1:0]  : addr_q[1:0];

  mem_lane_ctl u_lane (
    .size_i     (ln_size),
    .off_i      (ln_off),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata),
    .be_o       (ln_be),
    .wdata_o    (ln_wdata),
    .rdata_o    (ln_rdata),
    .misalign_o (ln_misalign)
  );

  assign fault = (req_addr >= 32'(MEM_BYTES)) || ln_misalign;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt)        state_d = fault ? S_RESP : S_ISSUE;
      S_ISSUE: if (mem_ready)  state_d = S_WAIT;
      S_WAIT:  if (mem_rvalid) state_d = S_RESP;
      S_RESP:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Request latch, starvation counter, response data and fault counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_q    <= OWN_I;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      starve_q <= '0;
      seg_q    <= '0;
    end else if (idle) begin
      if (!i_req || gnt_i) starve_q <= '0;
      else if (gnt_d)      starve_q <= starve_q + 8'd1;
      if (gnt) begin
        own_q   <= gnt_d ? OWN_D : OWN_I;
        addr_q  <= req_addr;
        size_q  <= req_size;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        err_q   <= fault;
        if (fault) begin
          rdata_q <= '0;
          if (seg_q != 8'hFF) seg_q <= seg_q + 8'd1;
        end
      end
    end else if ((state_q == S_WAIT) && mem_rvalid) begin
      rdata_q <= ln_rdata;
    end
  end

  // Memory side is driven only while issuing, zero otherwise.
  assign mem_valid = issue;
  assign mem_we    = issue && we_q;
  assign mem_be    = issue ? ln_be : 4'b0000;
  assign mem_addr  = issue ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = issue ? ln_wdata : 32'h0;

  // Responses go to the owner only, for the single RESP cycle.
  assign i_rvalid   = resp && (own_q == OWN_I);
  assign d_rvalid   = resp && (own_q == OWN_D);
  assign i_err      = i_rvalid && err_q;
  assign d_err      = d_rvalid && err_q;
  assign i_rdata    = i_rvalid ? rdata_q : 32'h0;
  assign d_rdata    = d_rvalid ? rdata_q : 32'h0;
  assign seg_faults = seg_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified memory between the CPU's instruction-fetch path and its load/store path.
- Grants one transaction at a time. Data has priority over fetch, with a starvation guard so fetch still gets through.
- Checks every request for out-of-range or misaligned access and answers faulting requests locally, without touching memory.
- Keeps a saturating fault count that feeds the CPU's seg_faults output.

Parameters:
- MEM_BYTES, 4096: memory size in bytes. Legal addresses are 0 to MEM_BYTES-1.
- STARVE_MAX, 4: maximum number of consecutive data grants allowed while a fetch is pending.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held until i_rvalid
- i_addr  in  32  fetch byte address
- i_rvalid  out  1  one-cycle fetch response strobe
- i_rdata  out  32  instruction word
- i_err  out  1  fetch fault, qualified by i_rvalid
- d_req  in  1  data request; held until d_rvalid
- d_we  in  1  1 = store
- d_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_rvalid  out  1  one-cycle data response strobe
- d_rdata  out  32  load word shifted right by 8*addr[1:0]
- d_err  out  1  data fault, qualified by d_rvalid
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts the request
- mem_we  out  1  memory write enable
- mem_be  out  4  byte enables
- mem_addr  out  32  word-aligned address ({addr[31:2], 2'b00})
- mem_wdata  out  32  store data replicated across lanes
- mem_rvalid  in  1  memory completion; read data or write acknowledge
- mem_rdata  in  32  memory read data
- seg_faults  out  8  saturating fault count

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All outputs 0: i_rvalid, d_rvalid, i_err, d_err, mem_valid, mem_we, mem_be, mem_addr, mem_wdata, i_rdata, d_rdata, seg_faults.
  - Starvation counter = 0.
  - Any in-flight transaction is abandoned. No response is ever issued for it. A late mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - If d_req and (no i_req, or starve < STARVE_MAX): grant data.
  - Else if i_req: grant fetch.
  - On a grant, latch owner, address, we, size and wdata.
  - starve counter: increments when data wins while i_req is pending; clears when fetch is granted; clears when i_req is low in IDLE.
- Fault check, done in IDLE on the granted request:
  - addr >= MEM_BYTES is a fault.
  - Fetch: addr[1:0] != 0 is a fault.
  - Data: half with addr[0] set is a fault; word with addr[1:0] != 0 is a fault; size 11 is a fault.
  - Fault path: go to RESP with err = 1 and rdata = 0. mem_valid is never asserted.
  - seg_faults increments by 1, saturating at 255.
- ISSUE:
  - mem_valid = 1 with stable address, we, be and wdata until mem_ready.
  - On the mem_ready cycle, go to WAIT.
- WAIT:
  - Hold until mem_rvalid, then latch mem_rdata and go to RESP.
  - Memory never asserts mem_rvalid in the same cycle as the mem_ready handshake.
- RESP:
  - Owner's rvalid = 1 for exactly one cycle with registered rdata and err. Then go to IDLE.
  - Next grant earliest in the following IDLE cycle. Requesters may change req/addr in the cycle after rvalid.
- Byte enables:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0].
  - Word: 1111.
  - Fetch: 1111.
- mem_wdata lane replication:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load data returned is the word shifted right by 8*addr[1:0]. No sign or zero extension; that stays in the CPU.
- Latency with zero-wait memory (mem_ready = 1, mem_rvalid one cycle later):
  - Grant in cycle 0, mem_valid in cycle 1, mem_rvalid in cycle 2, requester rvalid in cycle 3.
  - Fault latency: grant in cycle 0, rvalid in cycle 1.
- Simultaneous d_req and i_req after STARVE_MAX consecutive data grants: fetch wins.
- Requests arriving outside IDLE wait. They are not queued beyond the held req.

Decomposition:
- Shared package: FSM state encoding; size codes (SZ_B = 00, SZ_H = 01, SZ_W = 10); owner encoding (OWN_I, OWN_D).
- One sub-module, mem_lane_ctl: combinational generation of be, replicated wdata, shifted rdata and the alignment fault flag from size and addr[1:0].

Test Plan:
- Fetch only, addr 0x10, zero-wait memory, mem_rdata 0x00500093 -> mem_valid in cycle 1; i_rvalid in cycle 3 with i_rdata 0x00500093 and i_err 0.
- Store byte 0xAB at 0x103 -> mem_be 1000, mem_wdata 0xABABABAB, mem_addr 0x100, mem_we 1; d_rvalid pulses with d_err 0.
- d_req and i_req both held continuously -> exactly 4 data grants, then 1 fetch grant, pattern repeats; fetch is never starved.
- Load word at 0x1002 (misaligned) and at 0x2000 (out of range, MEM_BYTES 4096) -> no mem_valid; d_err 1 in cycle 1; seg_faults goes 0 -> 1 -> 2; after 300 faults it saturates at 255.
- mem_ready held low for 5 cycles -> mem_valid and all mem_* outputs stable for 5 cycles; response follows normally afterwards.
- rst driven low while in WAIT -> all outputs 0 immediately; a late mem_rvalid produces no i_rvalid or d_rvalid; next request is serviced normally.
